// File: rtl/double_match_scan.sv
`default_nettype none
// ============================================================================
// Module      : double_match_scan
// Description : Streams a packet of IEEE-754 doubles, compares every beat
//               against a held 64-bit key (+0 == -0, bit-exact otherwise) and
//               reports match count, first matching index and flags per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module double_match_scan #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [63:0]      key_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [63:0]      s_data,
  input  logic             s_last,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [IDX_W-1:0] r_count,
  output logic [IDX_W-1:0] r_first_idx,
  output logic             r_found,
  output logic             r_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] C_IDX_MAX = '1;
  localparam logic [IDX_W-1:0] C_IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [63:0]      r_key;
  logic [IDX_W-1:0] r_beat_idx;

  // stage-1 registers: one accepted beat's decision and position
  logic             r_s1_vld;
  logic             r_s1_match;
  logic             r_s1_last;
  logic             r_s1_sat;
  logic [IDX_W-1:0] r_s1_idx;

  logic w_eq;
  logic w_last_pend;
  logic w_accept;
  logic w_clear;
  logic w_key_we;

  // Equality: identical patterns, or both operands are a zero of either sign.
  assign w_eq = (s_data == r_key) ||
                ((s_data[62:0] == 63'd0) && (r_key[62:0] == 63'd0));

  // The last beat sits in stage 1 for one cycle before DRAIN; the stream is
  // already closed during that cycle so the next packet cannot slip in.
  assign w_last_pend = r_s1_vld & r_s1_last;
  assign s_ready     = (r_state == ST_SCAN) && !w_last_pend;
  assign w_accept    = s_valid & s_ready;
  assign r_valid     = (r_state == ST_REPORT);
  assign w_clear     = (r_state == ST_REPORT) && r_ready;
  assign w_key_we    = key_load && ((r_state == ST_IDLE) || (r_state == ST_REPORT));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (key_load)    w_state_nxt = ST_SCAN;
      ST_SCAN:   if (w_last_pend) w_state_nxt = ST_DRAIN;
      ST_DRAIN:                   w_state_nxt = ST_REPORT;
      ST_REPORT: if (r_ready)     w_state_nxt = ST_SCAN;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Key register: writable only while no packet is in flight
  always_ff @(posedge clk) begin
    if (!rst_n)        r_key <= 64'd0;
    else if (w_key_we) r_key <= key_in;
  end

  // Stage 1 and the saturating beat index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_match <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_s1_idx   <= '0;
      r_beat_idx <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_match <= w_eq;
        r_s1_last  <= s_last;
        r_s1_sat   <= (r_beat_idx == C_IDX_MAX);
        r_s1_idx   <= r_beat_idx;
        if (r_beat_idx != C_IDX_MAX) r_beat_idx <= r_beat_idx + C_IDX_ONE;
      end else if (w_clear) begin
        r_beat_idx <= '0;
      end
    end
  end

  // Result accumulation; cleared when the result is taken
  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_count     <= '0;
      r_first_idx <= '0;
      r_found     <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (r_s1_vld) begin
      if (r_s1_match) begin
        if (r_count != C_IDX_MAX) r_count <= r_count + C_IDX_ONE;
        if (!r_found) begin
          r_found     <= 1'b1;
          r_first_idx <= r_s1_idx;
        end
      end
      if (r_s1_sat) r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_double_match_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_double_match_scan
// Description : Self-checking bench; two instances (IDX_W=16 and IDX_W=2)
//               share stimulus and are compared against a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_double_match_scan;

  localparam logic [63:0] C_ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] C_TWO   = 64'h4000000000000000;
  localparam logic [63:0] C_THREE = 64'h4008000000000000;
  localparam logic [63:0] C_PZERO = 64'h0000000000000000;
  localparam logic [63:0] C_NZERO = 64'h8000000000000000;
  localparam logic [63:0] C_QNAN  = 64'h7FF8000000000000;
  localparam logic [63:0] C_QNAN1 = 64'h7FF8000000000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_load;
  logic [63:0] key_in;
  logic        s_valid;
  logic [63:0] s_data;
  logic        s_last;
  logic        r_ready;

  logic        s_ready_a, r_valid_a, r_found_a, r_overflow_a;
  logic [15:0] r_count_a, r_first_idx_a;
  logic        s_ready_b, r_valid_b, r_found_b, r_overflow_b;
  logic [1:0]  r_count_b, r_first_idx_b;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] cur_key;
  logic [63:0] last_pkt[$];

  always #5 clk = ~clk;

  double_match_scan #(.IDX_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data), .s_last(s_last),
    .r_valid(r_valid_a), .r_ready(r_ready), .r_count(r_count_a),
    .r_first_idx(r_first_idx_a), .r_found(r_found_a), .r_overflow(r_overflow_a)
  );

  double_match_scan #(.IDX_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data), .s_last(s_last),
    .r_valid(r_valid_b), .r_ready(r_ready), .r_count(r_count_b),
    .r_first_idx(r_first_idx_b), .r_found(r_found_b), .r_overflow(r_overflow_b)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
    end
  endtask

  // advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // packet-level reference: results of a whole packet for a given index width
  function automatic void model(input logic [63:0] q[$], input logic [63:0] key, input int w,
                                output int cnt, output int first, output bit found, output bit ovf);
    int  mx;
    bit  eq;
    logic [63:0] d;
    mx = (1 << w) - 1;
    cnt = 0; first = 0; found = 0; ovf = 0;
    for (int i = 0; i < q.size(); i++) begin
      d  = q[i];
      eq = (d == key) || ((d[62:0] == 63'd0) && (key[62:0] == 63'd0));
      if (i >= mx) ovf = 1;
      if (eq) begin
        if (!found) begin found = 1; first = (i < mx) ? i : mx; end
        if (cnt < mx) cnt++;
      end
    end
  endfunction

  task automatic check_result();
    int c, f; bit fd, ov;
    model(last_pkt, cur_key, 16, c, f, fd, ov);
    check_val("a_r_valid", 64'(r_valid_a), 64'd1);
    check_val("a_r_count", 64'(r_count_a), 64'(c));
    check_val("a_r_first_idx", 64'(r_first_idx_a), 64'(f));
    check_val("a_r_found", 64'(r_found_a), 64'(fd));
    check_val("a_r_overflow", 64'(r_overflow_a), 64'(ov));
    model(last_pkt, cur_key, 2, c, f, fd, ov);
    check_val("b_r_valid", 64'(r_valid_b), 64'd1);
    check_val("b_r_count", 64'(r_count_b), 64'(c));
    check_val("b_r_first_idx", 64'(r_first_idx_b), 64'(f));
    check_val("b_r_found", 64'(r_found_b), 64'(fd));
    check_val("b_r_overflow", 64'(r_overflow_b), 64'(ov));
  endtask

  task automatic load_key_idle(input logic [63:0] k);
    key_load = 1'b1; key_in = k;
    tick();
    key_load = 1'b0;
    cur_key  = k;
    check_val("idle_key_load_s_ready", 64'(s_ready_a), 64'd1);
  endtask

  // sends one packet; kl_mid drives an (ignored) key_load during the packet
  task automatic send_packet(input logic [63:0] beats[$], input bit kl_mid, input bit gaps);
    int w;
    last_pkt = beats;
    for (int i = 0; i < beats.size(); i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      s_valid = 1'b1; s_data = beats[i]; s_last = (i == beats.size() - 1);
      if (kl_mid) begin key_load = 1'b1; key_in = C_TWO; end
      w = 0;
      while (!s_ready_a && w < 20) begin tick(); w++; end
      if (w >= 20) begin
        check_val("s_ready_timeout", 64'(s_ready_a), 64'd1);
        s_valid = 1'b0; key_load = 1'b0;
        return;
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0; key_load = 1'b0;
    check_val("lat_e0_r_valid", 64'(r_valid_a), 64'd0);
    check_val("lat_e0_s_ready", 64'(s_ready_a), 64'd0);
    tick();
    check_val("lat_e1_r_valid", 64'(r_valid_a), 64'd0);
    tick();
    check_val("lat_e2_r_valid", 64'(r_valid_a), 64'd1);
  endtask

  // holds the result, then accepts it, optionally reloading the key
  task automatic finish_report(input bit do_kl, input logic [63:0] k, input int hold, input bit drive_sv);
    for (int i = 0; i < hold; i++) begin
      if (drive_sv) begin s_valid = 1'b1; s_data = C_ONE; s_last = 1'b1; end
      if (do_kl) begin key_load = 1'b1; key_in = k; end
      tick();
      check_val("hold_s_ready", 64'(s_ready_a), 64'd0);
      check_result();
    end
    s_valid = 1'b0; s_last = 1'b0;
    r_ready = 1'b1;
    if (do_kl) begin key_load = 1'b1; key_in = k; end
    tick();
    r_ready = 1'b0; key_load = 1'b0;
    if (do_kl) cur_key = k;
    check_val("post_ack_r_valid", 64'(r_valid_a), 64'd0);
    check_val("post_ack_s_ready", 64'(s_ready_a), 64'd1);
    check_val("post_ack_r_count", 64'(r_count_a), 64'd0);
    check_val("post_ack_b_ovf", 64'(r_overflow_b), 64'd0);
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0: v = C_ONE;
      1: v = C_TWO;
      2: v = C_PZERO;
      3: v = C_NZERO;
      4: v = C_QNAN;
      5: v = C_QNAN1;
      6: v = C_ONE;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] q[$];
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; s_valid = 1'b0;
    s_data = '0; s_last = 1'b0; r_ready = 1'b0; cur_key = '0;
    tick(); tick();
    check_val("rst_s_ready", 64'(s_ready_a), 64'd0);
    check_val("rst_r_valid", 64'(r_valid_a), 64'd0);
    check_val("rst_r_count", 64'(r_count_a), 64'd0);
    check_val("rst_r_first_idx", 64'(r_first_idx_a), 64'd0);
    check_val("rst_r_found", 64'(r_found_a), 64'd0);
    check_val("rst_r_overflow", 64'(r_overflow_a), 64'd0);
    check_val("rst_b_r_valid", 64'(r_valid_b), 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("idle_s_ready", 64'(s_ready_a), 64'd0);

    // back-to-back packet, key 1.0
    load_key_idle(C_ONE);
    q = {C_TWO, C_ONE, C_THREE, C_ONE};
    send_packet(q, 1'b0, 1'b0);
    check_result();
    finish_report(1'b1, C_PZERO, 0, 1'b0);

    // -0 matches +0 key, single-beat packet
    q = {C_NZERO};
    send_packet(q, 1'b0, 1'b0);
    check_result();
    finish_report(1'b1, C_QNAN, 0, 1'b0);

    // NaN payloads must match bit-exactly
    q = {C_QNAN1, C_QNAN};
    send_packet(q, 1'b0, 1'b0);
    check_result();
    finish_report(1'b1, C_TWO, 5, 1'b1);

    q = {C_TWO};
    send_packet(q, 1'b0, 1'b0);
    check_result();
    finish_report(1'b1, C_ONE, 2, 1'b0);

    // key_load mid-packet is ignored
    q = {C_ONE, C_TWO, C_ONE, C_TWO, C_TWO};
    send_packet(q, 1'b1, 1'b1);
    check_result();
    finish_report(1'b0, C_ONE, 0, 1'b0);

    // saturation on the narrow instance
    q = {C_ONE, C_ONE, C_ONE, C_ONE, C_ONE};
    send_packet(q, 1'b0, 1'b1);
    check_result();
    finish_report(1'b0, C_ONE, 1, 1'b0);

    // randomized packets
    for (int n = 0; n < 25; n++) begin
      q = {};
      repeat ($urandom_range(1, 7)) q.push_back(pick());
      send_packet(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_result();
      finish_report(1'($urandom_range(0, 1)), pick(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a packet
    s_valid = 1'b1; s_data = C_ONE; s_last = 1'b0;
    tick(); tick();
    s_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("midrst_r_valid", 64'(r_valid_a), 64'd0);
    check_val("midrst_s_ready", 64'(s_ready_a), 64'd0);
    check_val("midrst_b_s_ready", 64'(s_ready_b), 64'd0);
    s_valid = 1'b1;
    tick(); tick(); tick();
    s_valid = 1'b0;
    check_val("midrst_idle_s_ready", 64'(s_ready_a), 64'd0);
    check_val("midrst_idle_r_valid", 64'(r_valid_a), 64'd0);
    load_key_idle(C_TWO);
    q = {C_TWO, C_ONE};
    send_packet(q, 1'b0, 1'b0);
    check_result();
    finish_report(1'b0, C_ONE, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/double_match_scan.md
Name: double_match_scan

Overview:
- Streaming consumer of double-precision equality decisions.
- Holds a 64-bit key. Accepts a packet of IEEE-754 doubles over a valid/ready stream and compares each beat against the key.
- At end of packet, reports the match count, the first matching index and status flags on a valid/ready result port.
- Sits downstream of the team's double comparator; the per-beat equality decision is registered inside this block.

Parameters:
- IDX_W, 16, width of the beat index, match count and first-index outputs.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- key_load  input  1  load key_in as the new key (honoured only in IDLE or REPORT)
- key_in  input  64  key value, IEEE-754 double bit pattern
- s_valid  input  1  stream beat valid
- s_ready  output  1  stream beat ready
- s_data  input  64  stream beat, IEEE-754 double bit pattern
- s_last  input  1  final beat of packet
- r_valid  output  1  result valid
- r_ready  input  1  result accepted
- r_count  output  IDX_W  number of matching beats in packet
- r_first_idx  output  IDX_W  zero-based index of first match (0 if none)
- r_found  output  1  at least one match in packet
- r_overflow  output  1  packet longer than 2^IDX_W-1 beats; index/count saturated

Behaviour:
- Reset: clk with rst_n=0 forces state IDLE, key invalid and all counters 0; s_ready=0, r_valid=0, r_count=0, r_first_idx=0, r_found=0, r_overflow=0. Reset mid-packet discards the partial packet and any pending result.
- Equality rule: beat equals key iff the 64-bit patterns are identical, or both are zeros of either sign (+0 == -0). Identical NaN patterns compare equal; differing NaN payloads do not.
- States:
  - IDLE: no key. s_ready=0. key_load -> SCAN.
  - SCAN: s_ready=1. A beat is accepted when s_valid&s_ready. Accepting a beat with s_last=1 -> DRAIN.
  - DRAIN: one cycle, s_ready=0. Final compare result folds into counters -> REPORT.
  - REPORT: r_valid=1, s_ready=0. Outputs are held stable while r_ready=0. On r_ready=1: counters and flags clear, then -> SCAN.
- Key loading:
  - key_load in REPORT updates the key for the next packet, with or without a simultaneous r_ready. It does not change the pending result.
  - key_load in SCAN or DRAIN is ignored.
- Pipeline:
  - Beat accepted at edge E: stage-1 registers the match bit and beat index at E. Counters update at E+1.
  - For the last beat accepted at edge E, r_valid is first high in the cycle after E+2.
  - A beat may be accepted every cycle in SCAN.
- Counters:
  - Beat index starts at 0 per packet and increments per accepted beat. It saturates at 2^IDX_W-1.
  - Any beat accepted while the index is saturated sets r_overflow.
  - r_count increments per match and saturates at 2^IDX_W-1.
  - r_first_idx latches the index of the first match only; r_found is set on that first match.
- Simultaneous events:
  - rst_n=0 overrides everything.
  - s_valid is ignored outside SCAN.
  - A single-beat packet (s_last on beat 0) is legal.
- The stream side must not be required to hold s_valid for any fixed time; gaps between beats are legal.

Test Plan:
- Reset, key_load 0x3FF0000000000000 (1.0); packet 0x4000000000000000, 0x3FF0000000000000, 0x4008000000000000, 0x3FF0000000000000(last), back-to-back -> r_count=2, r_first_idx=1, r_found=1, r_overflow=0; r_valid in the cycle after E+2 of the last beat.
- Key 0x0000000000000000; single-beat packet 0x8000000000000000(last) -> r_count=1, r_first_idx=0, r_found=1. Key 0x7FF8000000000000; packet 0x7FF8000000000001, 0x7FF8000000000000(last) -> r_count=1, r_first_idx=1.
- Hold r_ready=0 for 5 cycles in REPORT while driving s_valid=1 -> outputs stable, s_ready=0, no beat consumed. Then r_ready=1 together with key_load 0x4000000000000000 -> next packet 0x4000000000000000(last) gives r_count=1.
- key_load 0x4000000000000000 asserted mid-packet in SCAN with key 1.0 -> ignored; 1.0 beats still match, 2.0 beats do not.
- IDX_W=2, key 1.0, five 1.0 beats with irregular s_valid gaps -> r_count=3, r_first_idx=0, r_overflow=1.
- rst_n=0 for one cycle after two beats of a packet -> r_valid=0, state IDLE, s_ready=0 until key_load; the new packet reports only its own beats.
